// File: rtl/alu_arbiter.sv
// alu_arbiter
//
// Shares one combinational ALU between two requesters. Port 0 is the EX-stage
// requester, port 1 an auxiliary unit (CSR, address generation, ...). A granted
// request is registered into a single issue stage that drives the ALU. On the
// next edge the ALU result is captured into a one-entry response buffer owned by
// the issuing port. Port 0 can be flushed, which drops both its in-flight issue
// and its buffered response.
//
// Parameters
//   FIXED_PRIO     0: round-robin between eligible ports, 1: port 0 always wins
//
// Ports
//   clk, rst_n                     clock, asynchronous active-low reset
//   flush0                         drop all port-0 work this cycle
//   reqN_valid / reqN_ready        request handshake, ready is the grant
//   reqN_op, reqN_a, reqN_b        ALU opcode and operands
//   rspN_valid / rspN_ready        response handshake
//   rspN_result, rspN_zero         buffered ALU result and zero flag
//   alu_op_out, alu_a_out,
//   alu_b_out                      issue register contents, to the ALU
//   alu_result_in, alu_zero_in     ALU outputs

module alu_arbiter #(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush0,

  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_op,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,

  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_op,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,

  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic [31:0] rsp0_result,
  output logic        rsp0_zero,

  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp1_result,
  output logic        rsp1_zero,

  output logic [4:0]  alu_op_out,
  output logic [31:0] alu_a_out,
  output logic [31:0] alu_b_out,
  input  logic [31:0] alu_result_in,
  input  logic        alu_zero_in
);

  // Issue stage
  logic        iss_valid_q, iss_valid_d;
  logic        iss_id_q,    iss_id_d;
  logic [4:0]  op_q,        op_d;
  logic [31:0] a_q,         a_d;
  logic [31:0] b_q,         b_d;

  // Round-robin pointer: names the port preferred on a tie
  logic        prio_q,      prio_d;

  // Response buffers
  logic        rsp0_valid_q,  rsp0_valid_d;
  logic [31:0] rsp0_result_q, rsp0_result_d;
  logic        rsp0_zero_q,   rsp0_zero_d;
  logic        rsp1_valid_q,  rsp1_valid_d;
  logic [31:0] rsp1_result_q, rsp1_result_d;
  logic        rsp1_zero_q,   rsp1_zero_d;

  // Arbitration
  logic elig0, elig1;
  logic cand0, cand1;
  logic gnt0,  gnt1;
  logic land0, land1;

  always_comb begin
    // A port with its own op in flight is blocked, which caps each port at one
    // op every two cycles. A full response buffer only blocks its port when the
    // consumer is not draining it this cycle, so drain and refill overlap.
    elig0 = !(iss_valid_q && !iss_id_q) && (!rsp0_valid_q || rsp0_ready) && !flush0;
    elig1 = !(iss_valid_q &&  iss_id_q) && (!rsp1_valid_q || rsp1_ready);

    cand0 = req0_valid && elig0;
    cand1 = req1_valid && elig1;

    gnt0  = cand0 && (!cand1 || FIXED_PRIO || !prio_q);
    gnt1  = cand1 && !gnt0;

    // The issued op completes this edge; a flushed port-0 op is discarded.
    land0 = iss_valid_q && !iss_id_q && !flush0;
    land1 = iss_valid_q &&  iss_id_q;
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Issue register and round-robin pointer
  always_comb begin
    iss_valid_d = gnt0 || gnt1;
    iss_id_d    = iss_id_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    prio_d      = prio_q;
    if (gnt0) begin
      iss_id_d = 1'b0;
      op_d     = req0_op;
      a_d      = req0_a;
      b_d      = req0_b;
      prio_d   = 1'b1;
    end else if (gnt1) begin
      iss_id_d = 1'b1;
      op_d     = req1_op;
      a_d      = req1_a;
      b_d      = req1_b;
      prio_d   = 1'b0;
    end
  end

  // Response buffers: a landing result takes precedence over a drain, so the
  // buffer refills without a bubble. Flush beats a landing port-0 result.
  always_comb begin
    rsp0_valid_d  = rsp0_valid_q;
    rsp0_result_d = rsp0_result_q;
    rsp0_zero_d   = rsp0_zero_q;
    if (flush0) begin
      rsp0_valid_d = 1'b0;
    end else if (land0) begin
      rsp0_valid_d  = 1'b1;
      rsp0_result_d = alu_result_in;
      rsp0_zero_d   = alu_zero_in;
    end else if (rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    rsp1_valid_d  = rsp1_valid_q;
    rsp1_result_d = rsp1_result_q;
    rsp1_zero_d   = rsp1_zero_q;
    if (land1) begin
      rsp1_valid_d  = 1'b1;
      rsp1_result_d = alu_result_in;
      rsp1_zero_d   = alu_zero_in;
    end else if (rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iss_valid_q   <= 1'b0;
      iss_id_q      <= 1'b0;
      op_q          <= '0;
      a_q           <= '0;
      b_q           <= '0;
      prio_q        <= 1'b0;
      rsp0_valid_q  <= 1'b0;
      rsp0_result_q <= '0;
      rsp0_zero_q   <= 1'b0;
      rsp1_valid_q  <= 1'b0;
      rsp1_result_q <= '0;
      rsp1_zero_q   <= 1'b0;
    end else begin
      iss_valid_q   <= iss_valid_d;
      iss_id_q      <= iss_id_d;
      op_q          <= op_d;
      a_q           <= a_d;
      b_q           <= b_d;
      prio_q        <= prio_d;
      rsp0_valid_q  <= rsp0_valid_d;
      rsp0_result_q <= rsp0_result_d;
      rsp0_zero_q   <= rsp0_zero_d;
      rsp1_valid_q  <= rsp1_valid_d;
      rsp1_result_q <= rsp1_result_d;
      rsp1_zero_q   <= rsp1_zero_d;
    end
  end

  assign alu_op_out  = op_q;
  assign alu_a_out   = a_q;
  assign alu_b_out   = b_q;

  assign rsp0_valid  = rsp0_valid_q;
  assign rsp0_result = rsp0_result_q;
  assign rsp0_zero   = rsp0_zero_q;
  assign rsp1_valid  = rsp1_valid_q;
  assign rsp1_result = rsp1_result_q;
  assign rsp1_zero   = rsp1_zero_q;

  // Structural invariants of the arbiter
  a_one_grant: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && req1_ready));
  a_no_self_grant0: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && iss_valid_q && !iss_id_q));
  a_no_self_grant1: assert property (@(posedge clk) disable iff (!rst_n)
    !(req1_ready && iss_valid_q && iss_id_q));
  a_flush_blocks0: assert property (@(posedge clk) disable iff (!rst_n)
    !(req0_ready && flush0));

endmodule
